// File: rtl/egr_ppe_stm_arb.sv
// egr_ppe_stm_arb
//   Shares the egress PPE shared table memory (STM) among NREQ requesters.
//   Up to two reads per cycle go to STM read ports 1 and 2. One write per
//   cycle goes to the STM write port. Each read response comes back on the
//   tagged lane that matches the port the read was issued on.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rd_valid/rd_ready        per-requester read handshake (ready is combinational)
//   rd_addr, rd_cmask        read address and 72-bit chunk mask
//   wr_valid/wr_ready        per-requester write handshake (ready is combinational)
//   wr_addr, wr_cmask        write address and chunk enables
//   wr_data                  576-bit write data (ECC included)
//   rsp_valid/id/data        two response lanes: lane 0 = STM port 1, lane 1 = STM port 2
//   stm_wen, stm_ren         STM strobes; stm_ren[0] is port 1, stm_ren[1] is port 2
//   stm_addr                 [0] write address, [1]/[2] read addresses
//   stm_wdata, stm_rdata     STM write data, STM read data per read port
module egr_ppe_stm_arb #(
    parameter int  NREQ   = 4,
    parameter int  RD_LAT = 2,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        rd_valid,
    output logic [NREQ-1:0]        rd_ready,
    input  logic [NREQ-1:0][17:0]  rd_addr,
    input  logic [NREQ-1:0][7:0]   rd_cmask,
    input  logic [NREQ-1:0]        wr_valid,
    output logic [NREQ-1:0]        wr_ready,
    input  logic [NREQ-1:0][17:0]  wr_addr,
    input  logic [NREQ-1:0][7:0]   wr_cmask,
    input  logic [NREQ-1:0][575:0] wr_data,
    output logic [1:0]             rsp_valid,
    output logic [1:0][IDW-1:0]    rsp_id,
    output logic [1:0][575:0]      rsp_data,
    output logic [7:0]             stm_wen,
    output logic [1:0][7:0]        stm_ren,
    output logic [2:0][17:0]       stm_addr,
    output logic [575:0]           stm_wdata,
    input  logic [1:0][575:0]      stm_rdata
);

    // (base + off) mod NREQ, valid for off < NREQ; handles non-power-of-2 NREQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    function automatic logic [IDW-1:0] inc_idx(input logic [IDW-1:0] i);
        return (i == IDW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // Zero every 72-bit chunk whose mask bit is clear.
    function automatic logic [575:0] chunk_mask(input logic [575:0] d, input logic [7:0] m);
        logic [575:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[k*72 +: 72] = m[k] ? d[k*72 +: 72] : 72'd0;
        end
        return r;
    endfunction

    logic [IDW-1:0]       rd_ptr, rd_ptr_nxt;
    logic [IDW-1:0]       wr_ptr, wr_ptr_nxt;
    logic [NREQ-1:0]      rd_gnt, wr_gnt;
    logic [1:0]           rg_vld;
    logic [1:0][IDW-1:0]  rg_id;
    logic                 wg_vld;
    logic [IDW-1:0]       wg_id;

    logic [RD_LAT:0][1:0]          vld_p;
    logic [RD_LAT:0][1:0][IDW-1:0] id_p;
    logic [RD_LAT:0][1:0][7:0]     cm_p;

    // Read arbitration: rotate from rd_ptr, first hit -> port 1, second -> port 2.
    always_comb begin
        logic [IDW-1:0] idx;
        rd_gnt     = '0;
        rg_vld     = '0;
        rg_id      = '0;
        rd_ptr_nxt = rd_ptr;
        idx        = '0;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                idx = wrap_add(rd_ptr, i);
                if (rd_valid[idx] && !rg_vld[1]) begin
                    rd_gnt[idx] = 1'b1;
                    if (!rg_vld[0]) begin
                        rg_vld[0] = 1'b1;
                        rg_id[0]  = idx;
                    end else begin
                        rg_vld[1] = 1'b1;
                        rg_id[1]  = idx;
                    end
                    rd_ptr_nxt = inc_idx(idx);
                end
            end
        end
    end

    // Write arbitration: same rotation, single grant.
    always_comb begin
        logic [IDW-1:0] idx;
        wr_gnt     = '0;
        wg_vld     = 1'b0;
        wg_id      = '0;
        wr_ptr_nxt = wr_ptr;
        idx        = '0;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                idx = wrap_add(wr_ptr, i);
                if (wr_valid[idx] && !wg_vld) begin
                    wr_gnt[idx] = 1'b1;
                    wg_vld      = 1'b1;
                    wg_id       = idx;
                    wr_ptr_nxt  = inc_idx(idx);
                end
            end
        end
    end

    assign rd_ready = rd_gnt;
    assign wr_ready = wr_gnt;

    // ---- p0: issue register (STM strobes) and first response-tracking stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            stm_ren   <= '0;
            stm_wen   <= '0;
            stm_addr  <= '0;
            stm_wdata <= '0;
            vld_p     <= '0;
            id_p      <= '0;
            cm_p      <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr_nxt;
            for (int p = 0; p < 2; p++) begin
                stm_ren[p]  <= rg_vld[p] ? rd_cmask[rg_id[p]] : 8'd0;
                if (rg_vld[p]) stm_addr[p+1] <= rd_addr[rg_id[p]];
                vld_p[0][p] <= rg_vld[p];
                id_p[0][p]  <= rg_vld[p] ? rg_id[p] : '0;
                cm_p[0][p]  <= rg_vld[p] ? rd_cmask[rg_id[p]] : 8'd0;
            end
            stm_wen <= wg_vld ? wr_cmask[wg_id] : 8'd0;
            if (wg_vld) begin
                stm_addr[0] <= wr_addr[wg_id];
                stm_wdata   <= wr_data[wg_id];
            end
            // ---- p1..pRD_LAT: delay matching the STM read latency ----
            for (int s = 1; s <= RD_LAT; s++) begin
                vld_p[s] <= vld_p[s-1];
                id_p[s]  <= id_p[s-1];
                cm_p[s]  <= cm_p[s-1];
            end
        end
    end

    // ---- output: response lanes, masking combinational from stm_rdata ----
    assign rsp_valid = vld_p[RD_LAT];
    assign rsp_id    = id_p[RD_LAT];
    always_comb begin
        rsp_data = '0;
        for (int l = 0; l < 2; l++) begin
            rsp_data[l] = chunk_mask(stm_rdata[l], cm_p[RD_LAT][l]);
        end
    end

endmodule

// File: tb/tb_egr_ppe_stm_arb.sv
// Testbench for egr_ppe_stm_arb (NREQ = 4, RD_LAT = 2).
module tb_egr_ppe_stm_arb;
    localparam int NREQ   = 4;
    localparam int RD_LAT = 2;
    localparam int IDW    = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        rd_valid, rd_ready;
    logic [NREQ-1:0][17:0]  rd_addr;
    logic [NREQ-1:0][7:0]   rd_cmask;
    logic [NREQ-1:0]        wr_valid, wr_ready;
    logic [NREQ-1:0][17:0]  wr_addr;
    logic [NREQ-1:0][7:0]   wr_cmask;
    logic [NREQ-1:0][575:0] wr_data;
    logic [1:0]             rsp_valid;
    logic [1:0][IDW-1:0]    rsp_id;
    logic [1:0][575:0]      rsp_data;
    logic [7:0]             stm_wen;
    logic [1:0][7:0]        stm_ren;
    logic [2:0][17:0]       stm_addr;
    logic [575:0]           stm_wdata;
    logic [1:0][575:0]      stm_rdata;

    always #5 clk = ~clk;

    egr_ppe_stm_arb #(.NREQ(NREQ), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_cmask(rd_cmask),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_cmask(wr_cmask),
        .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .stm_wen(stm_wen), .stm_ren(stm_ren), .stm_addr(stm_addr),
        .stm_wdata(stm_wdata), .stm_rdata(stm_rdata)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit started = 1'b0;

    // Reference model state.
    int           m_rd_ptr, m_wr_ptr;
    logic [7:0]   e_ren [2];
    logic [17:0]  e_addr [3];
    logic [7:0]   e_wen;
    logic [575:0] e_wdata;

    typedef struct { int due; int lane; int id; logic [7:0] cm; } rsp_t;
    rsp_t pend[$];

    typedef struct { logic [3:0] rdv; logic [3:0] wrv; logic [3:0] exp_rd; logic [3:0] exp_wr; } vec_t;
    vec_t tbl [10];

    task automatic cmp(input string nm, input logic [575:0] act, input logic [575:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Pick up to maxg requesters: valid ones closest (cyclically) at or after ptr.
    function automatic void pick(input logic [NREQ-1:0] v, input int ptr, input int maxg,
                                 output int n, output int g0, output int g1);
        int got [2];
        n = 0; got[0] = -1; got[1] = -1;
        for (int k = 0; k < maxg; k++) begin
            int best;
            int bestd;
            best = -1; bestd = NREQ;
            for (int r = 0; r < NREQ; r++) begin
                int d;
                d = (r - ptr + NREQ) % NREQ;
                if (v[r] && r != got[0] && d < bestd) begin
                    best = r; bestd = d;
                end
            end
            if (best >= 0) begin
                got[n] = best; n++;
            end
        end
        g0 = got[0]; g1 = got[1];
    endfunction

    task automatic check_now();
        int n, g0, g1;
        logic [3:0] er, ew;
        if (!started) return;
        er = '0; ew = '0;
        if (!rst) begin
            pick(rd_valid, m_rd_ptr, 2, n, g0, g1);
            if (n > 0) er[g0] = 1'b1;
            if (n > 1) er[g1] = 1'b1;
            pick(wr_valid, m_wr_ptr, 1, n, g0, g1);
            if (n > 0) ew[g0] = 1'b1;
        end
        cmp("rd_ready", 576'(rd_ready), 576'(er));
        cmp("wr_ready", 576'(wr_ready), 576'(ew));
        cmp("stm_ren0", 576'(stm_ren[0]), 576'(e_ren[0]));
        cmp("stm_ren1", 576'(stm_ren[1]), 576'(e_ren[1]));
        for (int a = 0; a < 3; a++) cmp($sformatf("stm_addr%0d", a), 576'(stm_addr[a]), 576'(e_addr[a]));
        cmp("stm_wen", 576'(stm_wen), 576'(e_wen));
        cmp("stm_wdata", stm_wdata, e_wdata);
        for (int l = 0; l < 2; l++) begin
            logic         ev;
            logic [1:0]   eid;
            logic [7:0]   ecm;
            logic [575:0] ed;
            ev = 1'b0; eid = '0; ecm = '0;
            foreach (pend[i]) begin
                if (pend[i].due == cyc && pend[i].lane == l) begin
                    ev = 1'b1; eid = 2'(pend[i].id); ecm = pend[i].cm;
                end
            end
            for (int k = 0; k < 8; k++) ed[k*72 +: 72] = ecm[k] ? stm_rdata[l][k*72 +: 72] : 72'd0;
            cmp($sformatf("rsp_valid%0d", l), 576'(rsp_valid[l]), 576'(ev));
            cmp($sformatf("rsp_id%0d", l), 576'(rsp_id[l]), 576'(eid));
            cmp($sformatf("rsp_data%0d", l), rsp_data[l], ed);
        end
    endtask

    task automatic update_now();
        int n, g0, g1;
        if (rst) begin
            m_rd_ptr = 0; m_wr_ptr = 0;
            e_ren[0] = '0; e_ren[1] = '0;
            for (int a = 0; a < 3; a++) e_addr[a] = '0;
            e_wen = '0; e_wdata = '0;
            pend.delete();
        end else begin
            pick(rd_valid, m_rd_ptr, 2, n, g0, g1);
            e_ren[0] = '0; e_ren[1] = '0;
            if (n > 0) begin
                e_ren[0] = rd_cmask[g0]; e_addr[1] = rd_addr[g0];
                pend.push_back(rsp_t'{cyc + 1 + RD_LAT, 0, g0, rd_cmask[g0]});
                m_rd_ptr = (g0 + 1) % NREQ;
            end
            if (n > 1) begin
                e_ren[1] = rd_cmask[g1]; e_addr[2] = rd_addr[g1];
                pend.push_back(rsp_t'{cyc + 1 + RD_LAT, 1, g1, rd_cmask[g1]});
                m_rd_ptr = (g1 + 1) % NREQ;
            end
            pick(wr_valid, m_wr_ptr, 1, n, g0, g1);
            e_wen = '0;
            if (n > 0) begin
                e_wen = wr_cmask[g0]; e_addr[0] = wr_addr[g0]; e_wdata = wr_data[g0];
                m_wr_ptr = (g0 + 1) % NREQ;
            end
        end
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].due <= cyc) pend.delete(i);
        end
        started = 1'b1;
        cyc++;
    endtask

    task automatic mid();
        @(negedge clk);
        check_now();
    endtask

    task automatic fin();
        @(posedge clk);
        update_now();
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) begin
            logic [31:0] t;
            t = $urandom; rd_addr[i] = t[17:0];
            t = $urandom; wr_addr[i] = t[17:0];
            t = $urandom; rd_cmask[i] = t[7:0]; wr_cmask[i] = t[15:8];
            for (int k = 0; k < 18; k++) wr_data[i][k*32 +: 32] = $urandom;
        end
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 18; k++) stm_rdata[l][k*32 +: 32] = $urandom;
        end
    endtask

    initial begin
        logic [575:0] ones_c0;
        logic [31:0]  t;
        ones_c0 = '0;
        ones_c0[71:0] = {72{1'b1}};

        // Expected readies derived by hand, starting from pointers 0/0 after reset.
        tbl[0] = '{4'b1111, 4'b0101, 4'b0011, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0101, 4'b1100, 4'b0100};
        tbl[2] = '{4'b1111, 4'b0101, 4'b0011, 4'b0001};
        tbl[3] = '{4'b1111, 4'b0000, 4'b1100, 4'b0000};
        tbl[4] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000};
        tbl[5] = '{4'b1001, 4'b1000, 4'b1001, 4'b1000};
        tbl[6] = '{4'b1111, 4'b1111, 4'b0110, 4'b0001};
        tbl[7] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[9] = '{4'b1010, 4'b0001, 4'b1010, 4'b0001};

        m_rd_ptr = 0; m_wr_ptr = 0;
        e_ren[0] = '0; e_ren[1] = '0;
        for (int a = 0; a < 3; a++) e_addr[a] = '0;
        e_wen = '0; e_wdata = '0;

        // Reset held 3 cycles with every request valid.
        rst = 1'b1; rd_valid = '1; wr_valid = '1;
        rand_data();
        for (int i = 0; i < 3; i++) begin
            mid();
            cmp("rst_rd_ready", 576'(rd_ready), 576'(0));
            cmp("rst_wr_ready", 576'(wr_ready), 576'(0));
            if (i >= 1) begin
                cmp("rst_rsp_valid", 576'(rsp_valid), 576'(0));
                cmp("rst_stm_ren", 576'(stm_ren), 576'(0));
                cmp("rst_stm_wen", 576'(stm_wen), 576'(0));
                cmp("rst_rsp_data0", rsp_data[0], 576'(0));
            end
            fin();
        end
        rst = 1'b0;

        // Table-driven arbitration sequence (full read load, write contention).
        for (int i = 0; i < 10; i++) begin
            rd_valid = tbl[i].rdv; wr_valid = tbl[i].wrv;
            mid();
            cmp($sformatf("tbl%0d_rd_ready", i), 576'(rd_ready), 576'(tbl[i].exp_rd));
            cmp($sformatf("tbl%0d_wr_ready", i), 576'(wr_ready), 576'(tbl[i].exp_wr));
            fin();
        end
        rd_valid = '0; wr_valid = '0;
        repeat (4) begin mid(); fin(); end

        // Single reader: requester 2, full mask (rd_ptr is 0 here).
        rd_cmask[2] = 8'hFF;
        rd_valid = 4'b0100;
        mid(); cmp("single_rd_ready", 576'(rd_ready), 576'(4'b0100)); fin();
        rd_valid = '0;
        mid();
        cmp("single_ren0", 576'(stm_ren[0]), 576'(8'hFF));
        cmp("single_ren1", 576'(stm_ren[1]), 576'(8'h00));
        fin();
        mid(); fin();
        mid();
        cmp("single_rsp_valid", 576'(rsp_valid), 576'(2'b01));
        cmp("single_rsp_id0", 576'(rsp_id[0]), 576'(2));
        fin();

        // Chunk masking: requester 0 mask 8'h01 on lane 0, requester 1 mask 0 on lane 1.
        stm_rdata[0] = '1; stm_rdata[1] = '1;
        rd_cmask[0] = 8'h01; rd_cmask[1] = 8'h00;
        rd_valid = 4'b0011;
        mid(); fin();
        rd_valid = '0;
        mid(); cmp("zmask_ren1", 576'(stm_ren[1]), 576'(0)); fin();
        mid(); fin();
        mid();
        cmp("mask_rsp_valid", 576'(rsp_valid), 576'(2'b11));
        cmp("mask_rsp_data0", rsp_data[0], ones_c0);
        cmp("zmask_rsp_data1", rsp_data[1], 576'(0));
        fin();

        // Reset mid-flight: read in flight is dropped, pointers return to 0.
        rd_valid = 4'b0001;
        mid(); fin();
        rd_valid = '0; rst = 1'b1;
        mid(); fin();
        rst = 1'b0;
        mid(); fin();
        mid(); cmp("flight_rsp_valid", 576'(rsp_valid), 576'(0)); fin();
        rd_valid = '1; wr_valid = '1;
        mid();
        cmp("post_rst_rd_ready", 576'(rd_ready), 576'(4'b0011));
        cmp("post_rst_wr_ready", 576'(wr_ready), 576'(4'b0001));
        fin();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            t = $urandom;
            rd_valid = t[3:0]; wr_valid = t[7:4];
            rand_data();
            mid(); fin();
        end
        rst = 1'b0; rd_valid = '0; wr_valid = '0;
        repeat (5) begin mid(); fin(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/egr_ppe_stm_arb.md
# egr_ppe_stm_arb

Arbiter that shares the egress PPE shared table memory (STM) ports among NREQ egress requesters. Reads go to the two STM read ports and writes to the single STM write port. Each read response returns to its issuer on one of two tagged response lanes. It sits between the egress PPE lookup engines and the egr_ppe_stm_if egr modport.

## Interface
Parameters:
- NREQ, 4, number of requesters; legal values 2..8. IDW = $clog2(NREQ).
- RD_LAT, 2, cycles from stm_ren/stm_addr driven to stm_rdata valid; legal values ≥1.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-high.
- rd_valid  in  NREQ  read request valid.
- rd_ready  out  NREQ  read grant; handshake when valid&ready.
- rd_addr  in  NREQ×18  read address.
- rd_cmask  in  NREQ×8  read chunk mask; chunk k = bits 72k+71:72k.
- wr_valid  in  NREQ  write request valid.
- wr_ready  out  NREQ  write grant.
- wr_addr  in  NREQ×18  write address.
- wr_cmask  in  NREQ×8  write chunk enables.
- wr_data  in  NREQ×576  write data, ECC included.
- rsp_valid  out  2  response lane valid.
- rsp_id  out  2×IDW  requester index per lane.
- rsp_data  out  2×576  masked read data per lane.
- stm_wen  out  8  to STM wen.
- stm_ren  out  2×8  to STM ren; [0] is port 1, [1] is port 2.
- stm_addr  out  3×18  to STM addr; [0] write, [1]/[2] read.
- stm_wdata  out  576  to STM wdata.
- stm_rdata  in  2×576  from STM rdata.

## Operation
- Read arbitration:
  - Round-robin pointer rd_ptr. Each cycle, scan from rd_ptr upward modulo NREQ.
  - The first valid requester is granted to lane/port 0 (STM port 1). The second valid requester is granted to lane/port 1 (STM port 2).
  - At most 2 read grants per cycle.
  - rd_ready is combinational from rd_valid and rd_ptr. It is never asserted without rd_valid.
  - rd_ptr advances to (last granted index + 1) mod NREQ. It is unchanged if nothing is granted.
- Write arbitration:
  - Independent round-robin pointer wr_ptr. One grant per cycle, using the same scan and advance rule.
- Issue register: grants are registered. On the cycle after a handshake:
  - stm_ren[p] = rd_cmask and stm_addr[p+1] = rd_addr for each read port p.
  - stm_wen = wr_cmask, stm_addr[0] = wr_addr, stm_wdata = wr_data.
  - A port without a grant drives ren/wen = 0. Its addr/wdata hold their last value.
- Response tracking:
  - Per-lane shift pipeline of RD_LAT+1 stages carries {valid, id, cmask}.
  - At the output stage: rsp_valid = stage valid, rsp_id = stage id.
  - rsp_data = stm_rdata with each chunk whose cmask bit is 0 forced to zero. The response path is combinational from stm_rdata.
- Zero-mask read (cmask = 0): still granted. It still produces rsp_valid, with all-zero data and stm_ren = 0.
- Lane ordering: lane 0 always carries the read issued on STM port 1; lane 1 carries STM port 2.
- Response backpressure: none; requesters must accept rsp_valid every cycle.
- Hazards: no forwarding and no hazard detection between reads and writes to the same address. Coherency is the requesters' responsibility.
- Reset:
  - Outputs: stm_wen, stm_ren, stm_addr, stm_wdata, rsp_valid, rsp_id, rsp_data all 0.
  - State: rd_ptr = wr_ptr = 0 and all pipeline valids cleared.
  - Reads in flight when rst asserts are dropped; no rsp_valid is produced for them.
  - rd_ready and wr_ready are forced to 0 while rst = 1.

## Timing
- Handshake at cycle T → STM strobes at T+1 → rsp_valid at T+1+RD_LAT. Read latency is RD_LAT+1 cycles from handshake.
- Write: handshake at T → stm_wen at T+1. No completion signal.
- Throughput:
  - Reads: 2 per cycle sustained.
  - Writes: 1 per cycle sustained.
  - Read and write grants are independent in the same cycle.
- Fairness: any continuously valid requester is granted within ceil(NREQ/2) cycles for reads and NREQ cycles for writes.
- The first cycle after rst deasserts may grant.

## Test plan
- Reset: hold rst 3 cycles with all valids high → rd_ready = wr_ready = 0 and all outputs 0. First cycle after release: rd_ready = 4'b0011, wr_ready = 4'b0001.
- Full read load, NREQ = 4, RD_LAT = 2, all rd_valid high for 4 cycles:
  - Grants are {0,1},{2,3},{0,1},{2,3}.
  - rsp_valid = 2'b11 starting 3 cycles after the first grant.
  - rsp_id lane0/lane1 = 0/1, then 2/3.
- Single reader: only requester 2 valid with cmask 8'hFF → stm_ren[0] = 8'hFF and stm_ren[1] = 0. rsp_valid = 2'b01 with rsp_id[0] = 2, 3 cycles after the handshake.
- Write contention: wr_valid = 4'b0101 held → wr_ready is 0001, then 0100, then 0001. stm_wen equals the granted requester's cmask one cycle after each grant.
- Chunk masking: rd_cmask = 8'h01 and the bench drives stm_rdata all ones → rsp_data bits 71:0 are ones and bits 575:72 are zero. A cmask = 8'h00 read returns rsp_valid with all-zero data.
- Reset mid-flight: read handshake at T, rst asserted at T+1 for 1 cycle → no rsp_valid at T+3. Pointers return to 0.
